// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the core and the responder.
// master drives requests; slave returns mem_out/ready/busy/err.
interface mem_responder_if;
  logic        read_mem;
  logic        write_mem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] mem_out;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output read_mem, write_mem,
    output addr, wdata, funct3,
    input  mem_out, ready, busy, err
  );

  modport slave (
    input  read_mem, write_mem,
    input  addr, wdata, funct3,
    output mem_out, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: word RAM with RV32I byte/half/word access.
// Ports: clk, rst (async high), bus (mem_responder_if.slave).
module mem_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  mem_responder_if.slave bus
);

  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam logic [2:0] CNT_INIT =
    3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP,
    RD_DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic        err_q, err_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;

  logic [31:0] ram [WORDS];

  logic                  req;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [1:0]            in_lane;
  logic [2:0]            in_f3;
  logic                  bad_size;
  logic                  misalign;
  logic                  bad;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wd;

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [1:0]            rd_lane;
  logic [2:0]            rd_f3;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_val;

  logic unused_addr;
  assign unused_addr =
    ^bus.addr[31:ADDR_WIDTH+2];

  assign req     = bus.read_mem | bus.write_mem;
  assign in_idx  = bus.addr[ADDR_WIDTH+1:2];
  assign in_lane = bus.addr[1:0];
  assign in_f3   = bus.funct3;

  always_comb begin
    bad_size = 1'b0;
    if (bus.write_mem)
      bad_size = !(in_f3 inside
        {3'b000, 3'b001, 3'b010});
    else
      bad_size = in_f3 inside
        {3'b011, 3'b110, 3'b111};
  end

  assign misalign =
    (in_f3[1:0] == 2'b01 && in_lane[0]) ||
    (in_f3[1:0] == 2'b10 && in_lane != 2'b00);
  assign bad = bad_size | misalign;

  // Store data replicated to every lane; be picks the lanes.
  always_comb begin
    be = 4'b0000;
    wd = bus.wdata;
    unique case (1'b1)
      (in_f3[1:0] == 2'b00): begin
        be = 4'b0001 << in_lane;
        wd = {4{bus.wdata[7:0]}};
      end
      (in_f3[1:0] == 2'b01): begin
        be = in_lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = bus.wdata;
      end
    endcase
  end

  assign we = (state_q == IDLE) &&
              bus.write_mem && !bad && !rst;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          ram[in_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // In IDLE the read path sees the live request so a
  // single-cycle latency can load mem_out at acceptance.
  assign rd_idx  = (state_q == IDLE) ? in_idx  : idx_q;
  assign rd_lane = (state_q == IDLE) ? in_lane : lane_q;
  assign rd_f3   = (state_q == IDLE) ? in_f3   : f3_q;
  assign rd_word = ram[rd_idx];
  assign rd_byte = rd_word[{rd_lane, 3'b000} +: 8];
  assign rd_half = rd_lane[1] ? rd_word[31:16]
                              : rd_word[15:0];

  always_comb begin
    case (rd_f3)
      3'b000:  ld_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_val = {24'h0, rd_byte};
      3'b101:  ld_val = {16'h0, rd_half};
      default: ld_val = rd_word;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_out_d = mem_out_q;
    err_d     = err_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    f3_d      = f3_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d  = in_idx;
          lane_d = in_lane;
          f3_d   = in_f3;
          err_d  = bad;
          if (bad || bus.write_mem) begin
            state_d = RESP;
          end else if (READ_LATENCY <= 1) begin
            mem_out_d = ld_val;
            state_d   = RD_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // cnt_q counts wait edges left, this one included
        if (cnt_q <= 3'd1) begin
          cnt_d     = 3'd0;
          mem_out_d = ld_val;
          state_d   = RD_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      mem_out_q <= 32'h0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_out_q <= mem_out_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
    end
  end

  assign bus.mem_out = mem_out_q;
  assign bus.ready   = (state_q == RESP) ||
                       (state_q == RD_DONE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.err     = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder.
// Defaults: ADDR_WIDTH=8, READ_LATENCY=2.
module tb_mem_responder;

  logic clk;
  logic rst;

  mem_responder_if bus ();

  mem_responder #(
    .ADDR_WIDTH  (8),
    .READ_LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_out = 32'h0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ready === 1'b1) begin
      chk("ready_expected",
          (sbq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("mem_out", bus.mem_out, e.data);
        chk("err", {31'h0, bus.err}, {31'h0, e.err});
      end
    end
  end

  task automatic do_req(input string tag,
                        input bit rd,
                        input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] wdat,
                        input logic [2:0] f3,
                        input logic [31:0] expd,
                        input bit e,
                        input int lat,
                        input bit noise);
    int   k;
    bit   got;
    exp_t ent;
    k = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.read_mem  = rd;
    bus.write_mem = wr;
    bus.addr      = a;
    bus.wdata     = wdat;
    bus.funct3    = f3;
    if (rd && !wr && !e) last_out = expd;
    ent.data = last_out;
    ent.err  = e;
    sbq.push_back(ent);
    @(posedge clk);
    #1;
    if (noise) begin
      bus.read_mem  = 1'b1;
      bus.write_mem = 1'b1;
      bus.addr      = 32'h10;
      bus.wdata     = 32'h5555_5555;
      bus.funct3    = 3'b010;
    end else begin
      bus.read_mem  = 1'b0;
      bus.write_mem = 1'b0;
      bus.addr      = 32'hFFFF_FFFC;
      bus.wdata     = 32'hA5A5_A5A5;
      bus.funct3    = 3'b010;
    end
    got = 1'b0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      chk({tag, "_busy"}, {31'h0, bus.busy}, 32'd1);
    end
    chk({tag, "_lat"}, got ? k : 0, lat);
    bus.read_mem  = 1'b0;
    bus.write_mem = 1'b0;
    if (got) begin
      @(negedge clk);
      chk({tag, "_after"},
          {29'h0, bus.ready, bus.err, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.read_mem  = 1'b0;
    bus.write_mem = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.funct3    = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_mem_out", bus.mem_out, 32'h0);
    chk("rst_flags",
        {29'h0, bus.ready, bus.err, bus.busy}, 32'd0);
    rst = 1'b0;

    do_req("sw_10", 0, 1, 32'h10, 32'hDEADBEEF,
           3'b010, 0, 0, 1, 0);
    do_req("lw_10a", 1, 0, 32'h10, 0,
           3'b010, 32'hDEADBEEF, 0, 2, 0);
    do_req("sb_13", 0, 1, 32'h13, 32'h1234567F,
           3'b000, 0, 0, 1, 0);
    do_req("lw_10b", 1, 0, 32'h10, 0,
           3'b010, 32'h7FADBEEF, 0, 2, 0);
    do_req("lb_12", 1, 0, 32'h12, 0,
           3'b000, 32'hFFFFFFAD, 0, 2, 0);
    do_req("lbu_12", 1, 0, 32'h12, 0,
           3'b100, 32'h000000AD, 0, 2, 0);
    do_req("lh_12", 1, 0, 32'h12, 0,
           3'b001, 32'h00007FAD, 0, 2, 0);
    do_req("lh_10", 1, 0, 32'h10, 0,
           3'b001, 32'hFFFFBEEF, 0, 2, 0);
    do_req("lhu_10", 1, 0, 32'h10, 0,
           3'b101, 32'h0000BEEF, 0, 2, 0);
    do_req("lw_11", 1, 0, 32'h11, 0,
           3'b010, 0, 1, 1, 0);
    do_req("sh_13", 0, 1, 32'h13, 32'hFFFFFFFF,
           3'b001, 0, 1, 1, 0);
    do_req("ld_f011", 1, 0, 32'h10, 0,
           3'b011, 0, 1, 1, 0);
    do_req("st_f100", 0, 1, 32'h10, 32'hFFFFFFFF,
           3'b100, 0, 1, 1, 0);
    do_req("lw_10c", 1, 0, 32'h10, 0,
           3'b010, 32'h7FADBEEF, 0, 2, 0);
    do_req("lw_410", 1, 0, 32'h410, 0,
           3'b010, 32'h7FADBEEF, 0, 2, 0);
    do_req("lw_noise", 1, 0, 32'h10, 0,
           3'b010, 32'h7FADBEEF, 0, 2, 1);
    do_req("sw_noise", 0, 1, 32'h20, 32'h11112222,
           3'b010, 0, 0, 1, 1);
    do_req("lw_10d", 1, 0, 32'h10, 0,
           3'b010, 32'h7FADBEEF, 0, 2, 0);
    do_req("rw_both", 1, 1, 32'h10, 32'h0,
           3'b010, 0, 0, 1, 0);
    do_req("lw_10e", 1, 0, 32'h10, 0,
           3'b010, 32'h00000000, 0, 2, 0);
    do_req("sw_cafe", 0, 1, 32'h10, 32'hCAFEF00D,
           3'b010, 0, 0, 1, 0);
    do_req("sh_12", 0, 1, 32'h12, 32'hAAAA9876,
           3'b001, 0, 0, 1, 0);
    do_req("lw_10f", 1, 0, 32'h10, 0,
           3'b010, 32'h9876F00D, 0, 2, 0);

    @(negedge clk);
    bus.read_mem = 1'b1;
    bus.addr     = 32'h10;
    bus.funct3   = 3'b010;
    @(posedge clk);
    #1;
    bus.read_mem = 1'b0;
    @(negedge clk);
    chk("rw_busy", {31'h0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_mem_out", bus.mem_out, 32'h0);
    chk("rstmid_flags",
        {29'h0, bus.ready, bus.err, bus.busy}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    last_out = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_noready",
          {31'h0, bus.ready}, 32'd0);
    end

    do_req("lw_10g", 1, 0, 32'h10, 0,
           3'b010, 32'h9876F00D, 0, 2, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Data-memory responder for the multicycle core: the slave end of the core's read_mem/write_mem memory interface.
- Holds a word-organised RAM and accepts one request at a time.
- Services RV32I byte, halfword and word loads and stores, with sign/zero extension and byte-lane merging.
- Returns load data on mem_out after a configurable latency, with a one-cycle ready pulse.

Parameters:
ADDR_WIDTH, 8, log2 of the number of 32-bit words (default 256 words = 1 KiB).
READ_LATENCY, 2, cycles from request acceptance to ready for loads; legal range 1..7.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
read_mem  input  1  load request, sampled in IDLE
write_mem  input  1  store request, sampled in IDLE; wins over read_mem if both high
addr  input  32  byte address of the access
wdata  input  32  store data; the low byte or halfword is used for sb/sh
funct3  input  3  access size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw
mem_out  output  32  extended load data; holds its value until the next successful load completes
ready  output  1  one-cycle pulse: request completed (load, store or error)
busy  output  1  high whenever state is not IDLE
err  output  1  one-cycle pulse coincident with ready: misaligned or illegal-size access

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, mem_out=0, ready=0, err=0, busy=0, latency counter=0.
  - RAM contents are not reset.
- States:
  - IDLE: accepts a request.
  - RD_WAIT: counts load latency.
  - RESP: ready cycle for stores and errors.
  - RD_DONE: ready cycle for loads.
- Acceptance:
  - A request is accepted at a rising edge where state=IDLE and (read_mem|write_mem)=1; that edge is E0.
  - addr, wdata and funct3 are captured at E0; later input changes have no effect.
  - Requests while busy=1 are ignored, never queued.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2) bytes.
- Error check at E0:
  - Error conditions: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; funct3 in {011,110,111}; store funct3 other than 000/001/010.
  - On error: no RAM access, state→RESP, ready=1 and err=1 in the cycle after E0, mem_out unchanged.
- Store (write_mem=1, no error):
  - RAM updated at E0 with byte enables; unselected bytes are preserved.
  - sb: byte lane addr[1:0] ← wdata[7:0].
  - sh: lanes {addr[1],0}+1 : {addr[1],0} ← wdata[15:0].
  - sw: whole word.
  - state→RESP, ready=1 in the cycle after E0.
- Load (read_mem=1, write_mem=0, no error):
  - state→RD_WAIT, counter loaded with READ_LATENCY-1.
  - Each edge in RD_WAIT decrements the counter. At the edge where counter=0, mem_out is loaded and state→RD_DONE.
  - With READ_LATENCY=1, E0 goes directly to RD_DONE and loads mem_out.
  - Result: ready=1 and the new mem_out are visible in cycle READ_LATENCY after E0.
  - Extraction: lb/lbu take the byte at lane addr[1:0]; lh/lhu take the halfword at addr[1]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
- RESP/RD_DONE→IDLE on the next edge. ready/err last exactly one cycle.
- Throughput: the earliest new acceptance is the edge after the ready cycle, so a store or error costs 2 cycles and a load costs READ_LATENCY+1 cycles.
- Reset mid-operation:
  - A load in RD_WAIT is aborted: no ready, mem_out is forced to 0.
  - A store already committed at E0 remains in RAM.
- busy is combinational from state: 0 in IDLE, 1 otherwise.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10, READ_LATENCY=2 → store ready 1 cycle after E0; load ready and mem_out=0xDEADBEEF exactly 2 cycles after its E0; busy high over RD_WAIT and RD_DONE.
- sb wdata=0x1234567F @0x13, then lw @0x10 → mem_out=0x7FADBEEF. lb @0x12 → 0xFFFFFFAD. lbu @0x12 → 0x000000AD. lh @0x12 → 0x00007FAD. lh @0x10 → 0xFFFFBEEF. lhu @0x10 → 0x0000BEEF.
- lw @0x11 and sh @0x13 → ready=1 and err=1 for one cycle each; mem_out keeps its prior value; lw @0x10 afterwards still returns 0x7FADBEEF.
- Aliasing and priority:
  - lw @0x410 (ADDR_WIDTH=8) → 0x7FADBEEF.
  - read_mem=write_mem=1 with sw 0x0 @0x10 → treated as a store; a later lw @0x10 returns 0x00000000.
  - Requests asserted during busy → ignored, with exactly one ready per accepted request.
- rst pulsed during RD_WAIT of lw @0x10 → no ready; mem_out=0, state IDLE. A new lw @0x10 then completes normally with the stored value.
